// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 encodings, FSM
// states and the access legality rule.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } lsu_state_t;

  // Unsigned variants exist only for loads; natural alignment per access size.
  function automatic logic lsu_legal(input logic       wen,
                                     input logic [2:0] funct3,
                                     input logic [1:0] offset);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_BU:   ok = ~wen;
      F3_H:    ok = ~offset[0];
      F3_HU:   ok = ~wen & ~offset[0];
      F3_W:    ok = (offset == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load data lane select and sign/zero extension of the aligned memory word.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{offset, 3'b000} +: 8];
  assign half_sel = word[{offset[1], 4'b0000} +: 16];

  always_comb begin
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'h0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'h0, half_sel};
      F3_W:    data = word;
      default: data = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: turns one core request into a single data-memory
// transaction and returns extended load data, holding the core via stall.
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_wen,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  lsu_state_t  state, state_next;
  logic        wen_q;
  logic [2:0]  funct3_q;
  logic [1:0]  offset_q;
  logic [7:0]  cnt, cnt_next;

  logic        accept, legal, timed_out, done;
  logic [3:0]  lane_mask;
  logic [31:0] lane_data;
  logic [31:0] load_data;

  assign accept    = (state == S_IDLE) & req_valid & ~rsp_valid;
  assign legal     = lsu_legal(req_wen, req_funct3, req_addr[1:0]);
  assign cnt_next  = cnt + 8'd1;
  assign timed_out = (cnt_next == TIMEOUT_CNT);
  // Read data (or write ack) may arrive together with the accepting handshake.
  assign done      = ((state == S_REQ) & mem_ready & mem_rvalid) |
                     ((state == S_WAIT) & mem_rvalid);

  assign mem_valid = (state == S_REQ);
  assign rsp_valid = (state == S_RESP);
  assign stall     = req_valid & ~rsp_valid;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case statements can leave a latch behind.
  always_comb begin
    lane_mask = 4'h0;
    lane_data = 32'h0;
    if (req_wen) begin
      case (req_funct3)
        F3_B: begin
          lane_mask = 4'b0001 << req_addr[1:0];
          lane_data = {4{req_wdata[7:0]}};
        end
        F3_H: begin
          lane_mask = 4'b0011 << req_addr[1:0];
          lane_data = {2{req_wdata[15:0]}};
        end
        F3_W: begin
          lane_mask = 4'hF;
          lane_data = req_wdata;
        end
        default: ;
      endcase
    end
  end

  lsu_extend u_extend (
    .funct3 (funct3_q),
    .offset (offset_q),
    .word   (mem_rdata),
    .data   (load_data)
  );

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = legal ? S_REQ : S_RESP;
      S_REQ: begin
        if (done || timed_out) state_next = S_RESP;
        else if (mem_ready)    state_next = S_WAIT;
      end
      S_WAIT:  if (done || timed_out) state_next = S_RESP;
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wen_q     <= 1'b0;
      funct3_q  <= 3'h0;
      offset_q  <= 2'h0;
      cnt       <= 8'h0;
      mem_addr  <= 32'h0;
      mem_wen   <= 1'b0;
      mem_wmask <= 4'h0;
      mem_wdata <= 32'h0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        wen_q     <= req_wen;
        funct3_q  <= req_funct3;
        offset_q  <= req_addr[1:0];
        cnt       <= 8'h0;
        mem_addr  <= {req_addr[31:2], 2'b00};
        mem_wen   <= req_wen;
        mem_wmask <= lane_mask;
        mem_wdata <= lane_data;
        rsp_rdata <= 32'h0;
        rsp_err   <= ~legal;
      end else if (state == S_REQ || state == S_WAIT) begin
        cnt <= cnt_next;
        if (done) begin
          rsp_rdata <= wen_q ? 32'h0 : load_data;
          rsp_err   <= 1'b0;
        end else if (timed_out) begin
          rsp_rdata <= 32'h0;
          rsp_err   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed accesses against an arithmetic model
// of the access rules, with a per-cycle output compare process.
module tb_lsu;
  import lsu_pkg::*;

  localparam int TIMEOUT_TB = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_wen = 1'b0;
  logic [2:0]  req_funct3 = 3'h0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        stall, rsp_valid, rsp_err, mem_valid, mem_wen;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int checks = 0;
  int errors = 0;

  bit          cmp_en = 1'b0;
  bit          in_access = 1'b0;
  bit          exp_legal, exp_wen, exp_err;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [3:0]  exp_wmask;

  lsu #(.TIMEOUT(TIMEOUT_TB)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_wen    (req_wen),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wen    (mem_wen),
    .mem_wmask  (mem_wmask),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- model: access rules as plain arithmetic ----
  function automatic int m_size(input int f3);
    return 1 << (f3 % 4);
  endfunction

  function automatic bit m_legal(input bit wen, input int f3, input logic [31:0] addr);
    if (wen && f3 > 2) return 1'b0;
    if (!wen && !(f3 inside {0, 1, 2, 4, 5})) return 1'b0;
    return (addr % m_size(f3)) == 0;
  endfunction

  function automatic logic [31:0] m_load(input int f3, input logic [31:0] addr, input logic [31:0] word);
    int          off, size;
    logic [31:0] v, top;
    off  = int'(addr % 4);
    size = m_size(f3);
    if (size == 4) return word;
    v   = (word >> (8 * off)) & ((32'd1 << (8 * size)) - 32'd1);
    top = 32'd1 << (8 * size - 1);
    if (f3 < 4 && v >= top) v = v - (top * 2);
    return v;
  endfunction

  function automatic logic [3:0] m_mask(input bit wen, input int f3, input logic [31:0] addr);
    int m;
    if (!wen) return 4'h0;
    m = ((1 << m_size(f3)) - 1) << int'(addr % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input int f3, input logic [31:0] wdata);
    case (m_size(f3))
      1:       return (wdata & 32'hFF) * 32'h01010101;
      2:       return (wdata & 32'hFFFF) * 32'h00010001;
      default: return wdata;
    endcase
  endfunction

  // ---- per-cycle compare against the model ----
  always @(negedge clk) begin
    if (cmp_en) begin
      check("stall", {31'h0, stall}, {31'h0, req_valid & ~rsp_valid});
      if (mem_valid) begin
        check("mem_valid_allowed", {31'h0, in_access & exp_legal}, 32'd1);
        check("mem_addr", mem_addr, exp_addr);
        check("mem_wen", {31'h0, mem_wen}, {31'h0, exp_wen});
        check("mem_wmask", {28'h0, mem_wmask}, {28'h0, exp_wmask});
        if (exp_wen) check("mem_wdata", mem_wdata, exp_wdata);
      end
      if (rsp_valid) begin
        check("rsp_expected", {31'h0, in_access}, 32'd1);
        if (in_access) begin
          check("rsp_rdata", rsp_rdata, exp_rdata);
          check("rsp_err", {31'h0, rsp_err}, {31'h0, exp_err});
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_valid"}, {31'h0, mem_valid}, 32'h0);
    check({tag, "_mem_wen"},   {31'h0, mem_wen},   32'h0);
    check({tag, "_mem_wmask"}, {28'h0, mem_wmask}, 32'h0);
    check({tag, "_mem_addr"},  mem_addr,           32'h0);
    check({tag, "_mem_wdata"}, mem_wdata,          32'h0);
    check({tag, "_rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
    check({tag, "_rsp_err"},   {31'h0, rsp_err},   32'h0);
    check({tag, "_rsp_rdata"}, rsp_rdata,          32'h0);
    check({tag, "_stall"},     {31'h0, stall},     32'h0);
  endtask

  // One access: ready arrives rdy_dly cycles after mem_valid first rises,
  // read data/ack rv_dly cycles after ready (0 = same cycle).
  task automatic access(input bit wen, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] word,
                        input int rdy_dly, input int rv_dly, input bit rv_never,
                        output int lat, output logic [31:0] got_rdata, output logic got_err,
                        output logic [3:0] got_mask, output logic [31:0] got_wdata);
    int rdy_cyc, rv_cyc, exp_lat;
    bit exp_to;
    rdy_cyc   = 1 + rdy_dly;
    rv_cyc    = rdy_cyc + rv_dly;
    exp_legal = m_legal(wen, int'(f3), addr);
    exp_addr  = {addr[31:2], 2'b00};
    exp_wen   = wen;
    exp_wmask = m_mask(wen, int'(f3), addr);
    exp_wdata = m_wdata(int'(f3), wdata);
    exp_to    = exp_legal && (rv_never || rv_cyc > TIMEOUT_TB);
    exp_err   = !exp_legal || exp_to;
    exp_rdata = (exp_err || wen) ? 32'h0 : m_load(int'(f3), addr, word);
    exp_lat   = !exp_legal ? 1 : (exp_to ? TIMEOUT_TB + 1 : rv_cyc + 1);
    lat = -1; got_rdata = 32'h0; got_err = 1'b0; got_mask = 4'h0; got_wdata = 32'h0;

    @(posedge clk); #1;
    req_valid = 1'b1; req_wen = wen; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    mem_rdata = word; in_access = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      mem_ready  = (n == rdy_cyc);
      mem_rvalid = !rv_never && (n == rv_cyc);
      @(negedge clk);
      if (mem_valid) begin
        got_mask  = mem_wmask;
        got_wdata = mem_wdata;
      end
      if (rsp_valid) begin
        lat = n; got_rdata = rsp_rdata; got_err = rsp_err;
        break;
      end
    end
    check("latency", lat, exp_lat);
    @(posedge clk); #1;
    req_valid = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; in_access = 1'b0;
    @(negedge clk);
    check("rsp_single_pulse", {31'h0, rsp_valid}, 32'h0);
  endtask

  int          lat;
  logic [31:0] rd, wd;
  logic        er;
  logic [3:0]  mk;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0; cmp_en = 1'b1;

    // LW zero-wait
    access(1'b0, F3_W, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0, lat, rd, er, mk, wd);
    check("lw_lat", lat, 32'd2);
    check("lw_rdata", rd, 32'hDEAD_BEEF);
    check("lw_err", {31'h0, er}, 32'h0);

    // Byte/halfword extraction and extension
    access(1'b0, F3_B, 32'h0000_0203, 32'h0, 32'h80FF_7F01, 1, 0, 1'b0, lat, rd, er, mk, wd);
    check("lb_rdata", rd, 32'hFFFF_FF80);
    access(1'b0, F3_BU, 32'h0000_0203, 32'h0, 32'h80FF_7F01, 0, 1, 1'b0, lat, rd, er, mk, wd);
    check("lbu_rdata", rd, 32'h0000_0080);
    access(1'b0, F3_H, 32'h0000_0202, 32'h0, 32'h80FF_7F01, 0, 0, 1'b0, lat, rd, er, mk, wd);
    check("lh_rdata", rd, 32'hFFFF_80FF);
    access(1'b0, F3_HU, 32'h0000_0202, 32'h0, 32'h80FF_7F01, 2, 0, 1'b0, lat, rd, er, mk, wd);
    check("lhu_rdata", rd, 32'h0000_80FF);
    access(1'b0, F3_BU, 32'h0000_0201, 32'h0, 32'h80FF_7F01, 0, 0, 1'b0, lat, rd, er, mk, wd);
    check("lbu_off1_rdata", rd, 32'h0000_007F);

    // Stores
    access(1'b1, F3_B, 32'h0000_0102, 32'h1234_5678, 32'h0, 0, 0, 1'b0, lat, rd, er, mk, wd);
    check("sb_mask", {28'h0, mk}, 32'h4);
    check("sb_wdata", wd, 32'h7878_7878);
    check("sb_rdata", rd, 32'h0);
    access(1'b1, F3_H, 32'h0000_0102, 32'h1234_5678, 32'h0, 1, 0, 1'b0, lat, rd, er, mk, wd);
    check("sh_mask", {28'h0, mk}, 32'hC);
    check("sh_wdata", wd, 32'h5678_5678);
    access(1'b1, F3_W, 32'h0000_0100, 32'hCAFE_F00D, 32'h0, 1, 1, 1'b0, lat, rd, er, mk, wd);
    check("sw_mask", {28'h0, mk}, 32'hF);
    check("sw_wdata", wd, 32'hCAFE_F00D);
    access(1'b1, F3_B, 32'h0000_0101, 32'h0000_00A5, 32'h0, 0, 0, 1'b0, lat, rd, er, mk, wd);
    check("sb_off1_mask", {28'h0, mk}, 32'h2);

    // Illegal accesses
    access(1'b0, F3_W, 32'h0000_0102, 32'h0, 32'hFFFF_FFFF, 0, 0, 1'b0, lat, rd, er, mk, wd);
    check("lw_misalign_lat", lat, 32'd1);
    check("lw_misalign_err", {31'h0, er}, 32'd1);
    check("lw_misalign_rdata", rd, 32'h0);
    access(1'b1, 3'd3, 32'h0000_0100, 32'h1, 32'h0, 0, 0, 1'b0, lat, rd, er, mk, wd);
    check("st_f3_3_err", {31'h0, er}, 32'd1);
    access(1'b0, F3_H, 32'h0000_0201, 32'h0, 32'h1234_5678, 0, 0, 1'b0, lat, rd, er, mk, wd);
    check("lh_odd_err", {31'h0, er}, 32'd1);
    access(1'b0, 3'd6, 32'h0000_0200, 32'h0, 32'h1234_5678, 0, 0, 1'b0, lat, rd, er, mk, wd);
    check("ld_f3_6_err", {31'h0, er}, 32'd1);
    access(1'b1, F3_BU, 32'h0000_0200, 32'h1, 32'h0, 0, 0, 1'b0, lat, rd, er, mk, wd);
    check("st_f3_4_err", {31'h0, er}, 32'd1);

    // Slow memory: ready after 3 cycles, data 2 cycles later
    access(1'b0, F3_W, 32'h0000_0400, 32'h0, 32'h0BAD_F00D, 3, 2, 1'b0, lat, rd, er, mk, wd);
    check("slow_lat", lat, 32'd7);
    check("slow_rdata", rd, 32'h0BAD_F00D);

    // Timeouts: stuck in WAIT, then stuck in REQ
    access(1'b0, F3_W, 32'h0000_0400, 32'h0, 32'h1111_1111, 0, 0, 1'b1, lat, rd, er, mk, wd);
    check("to_wait_lat", lat, 32'd9);
    check("to_wait_err", {31'h0, er}, 32'd1);
    access(1'b1, F3_W, 32'h0000_0400, 32'h2222_2222, 32'h0, 50, 0, 1'b0, lat, rd, er, mk, wd);
    check("to_req_lat", lat, 32'd9);
    check("to_req_err", {31'h0, er}, 32'd1);

    // Reset while waiting for a store acknowledge
    exp_legal = 1'b1; exp_addr = 32'h0000_0100; exp_wen = 1'b1;
    exp_wmask = 4'hF; exp_wdata = 32'hA5A5_A5A5; exp_err = 1'b0; exp_rdata = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_wen = 1'b1; req_funct3 = F3_W; req_addr = 32'h0000_0100;
    req_wdata = 32'hA5A5_A5A5; in_access = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    check("wait_mem_valid_low", {31'h0, mem_valid}, 32'h0);
    check("wait_wmask_held", {28'h0, mem_wmask}, 32'hF);
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0; in_access = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    @(posedge clk); #1;
    mem_rvalid = 1'b1;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_rsp", {31'h0, rsp_valid}, 32'h0);
      check("midrst_no_mem", {31'h0, mem_valid}, 32'h0);
    end

    // Unit still usable after the abandoned access
    access(1'b0, F3_H, 32'h0000_0600, 32'h0, 32'h0000_8001, 0, 0, 1'b0, lat, rd, er, mk, wd);
    check("post_rst_lh", rd, 32'hFFFF_8001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the single-cycle RV32I core. It sits directly downstream of the ALU: it takes the ALU result as the effective address and `src2` as store data, and drives a simple request/response data-memory port. It returns sign- or zero-extended load data for register write-back. While an access is outstanding it holds the core (PC and register-file write enable) through `stall`.

## Interface
- `TIMEOUT`, 255: cycles spent waiting in REQ+WAIT before the access is abandoned with an error; 8-bit counter.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: core requests a load/store; held high until `rsp_valid`.
- `req_wen` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `req_addr` in 32: effective address (ALU result).
- `req_wdata` in 32: store data (`src2`), LSB-aligned.
- `stall` out 1: `req_valid & ~rsp_valid`, combinational.
- `rsp_valid` out 1: one-cycle pulse; access complete.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_err` out 1: valid with `rsp_valid`; set on misalignment, illegal funct3 or timeout.
- `mem_valid` out 1: memory request; held until `mem_ready`.
- `mem_ready` in 1: memory accepts the request.
- `mem_addr` out 32: `{req_addr[31:2], 2'b00}`.
- `mem_wen` out 1: write request.
- `mem_wmask` out 4: byte-lane enables.
- `mem_wdata` out 32: store data, lane-shifted.
- `mem_rvalid` in 1: read data valid, or write acknowledge.
- `mem_rdata` in 32: full aligned word.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - When `req_valid` is high and `rsp_valid` is low, latch `req_wen`, `req_funct3`, `req_addr[1:0]`, the aligned address and the lane-shifted data/mask.
  - If the access is legal, go to REQ. Otherwise set the error flag and go to RESP.
- Legality:
  - Load funct3 must be in {0,1,2,4,5}; store funct3 must be in {0,1,2}. Anything else is illegal.
  - W accesses need `addr[1:0]==0`; H/HU accesses need `addr[0]==0`.
  - An illegal access never asserts `mem_valid`.
- Store lanes, with `o = addr[1:0]`:
  - SB: mask `4'b0001<<o`, data `{4{wdata[7:0]}}`.
  - SH: mask `4'b0011<<o`, data `{2{wdata[15:0]}}`.
  - SW: mask `4'hF`, data `wdata`.
  - Loads drive `mem_wmask = 0`.
- REQ:
  - `mem_valid = 1`, and all `mem_*` outputs are stable until the handshake.
  - When `mem_valid & mem_ready`, go to WAIT.
- WAIT:
  - On `mem_rvalid`, capture `mem_rdata` and go to RESP.
  - `mem_rvalid` is also accepted in the same cycle as `mem_ready`; in that case go REQ→RESP directly.
- Load extraction:
  - Select byte `mem_rdata[8*o+:8]` or halfword `mem_rdata[16*o[1]+:16]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Timeout:
  - The counter clears on leaving IDLE and increments every cycle in REQ or WAIT.
  - When count == `TIMEOUT`, force RESP with `rsp_err = 1` and drop `mem_valid`.
- RESP: `rsp_valid = 1` for exactly one cycle, then go to IDLE.
- `mem_rvalid` or `mem_ready` seen in IDLE or RESP is ignored.

## Timing
- Reset values: state IDLE, counter 0; `mem_valid`, `mem_wen`, `rsp_valid`, `rsp_err` = 0; `mem_wmask`, `mem_addr`, `mem_wdata`, `rsp_rdata` = 0.
- Reset mid-access: return to IDLE next edge, no response is produced, and a later `mem_rvalid` is ignored.
- Cycle 0: `req_valid` is sampled in IDLE.
- Cycle 1:
  - Legal access: `mem_valid` is high.
  - Illegal access: `rsp_valid` with `rsp_err` is high.
- Zero-wait memory (`mem_ready` and `mem_rvalid` both high in cycle 1): `rsp_valid` in cycle 2. Minimum legal latency is 2 cycles.
- `rsp_rdata`/`rsp_err` are registered and valid only while `rsp_valid` is high.
- IDLE does not re-accept the same request in the `rsp_valid` cycle. The core must advance its PC on `rsp_valid`, so `req_valid` from the next instruction is sampled the following cycle.

## Structure
- Shared package `lsu_pkg`:
  - funct3 constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - State enum `lsu_state_t`.
- One natural sub-module: `lsu_extend`, the combinational load-data select and extend (funct3, offset, word → 32-bit result).

## Test plan
- LW at 0x80000004, memory word 0xDEADBEEF, zero-wait → `mem_addr` = 0x80000004, `rsp_valid` at cycle 2, `rsp_rdata` = 0xDEADBEEF, `rsp_err` = 0, `stall` high cycles 0–1.
- LB/LBU at offset 3 of 0x80FF7F01 → LB gives 0xFFFFFF80, LBU gives 0x00000080. LH/LHU at offset 2 → 0xFFFF80FF and 0x000080FF.
- SB of wdata 0x12345678 at address 0x100 + 2 → `mem_wmask` = 4'b0100, `mem_wdata` = 0x78787878, `mem_wen` = 1. SH at offset 2 → mask 4'b1100.
- LW at 0x102, and store funct3 = 3 → no `mem_valid` ever; `rsp_valid` with `rsp_err` = 1 at cycle 1; `rsp_rdata` = 0.
- `mem_ready` delayed 3 cycles, then `mem_rvalid` 2 cycles later → `mem_valid` held with stable address/data throughout; `rsp_valid` once. With TIMEOUT = 8 and no `mem_rvalid` → `rsp_err` = 1 after 8 cycles in REQ/WAIT.
- `rst` asserted in WAIT, then `mem_rvalid` pulsed in IDLE → no `rsp_valid`; all outputs 0 the cycle after reset.
